interrupt_controller: RTL and testbench

Collects up to NUM_SRC external/peripheral interrupt lines, latches them as pending, applies per-source and global enables, and presents the single highest-priority request with its vector address to the pipeline hazard control unit's `interrupt`/`interrupt_vector_address` inputs. It holds the request until the hazard unit's `control_state` shows the Interrupt state (4'h2), then marks the source in service and blocks further requests until the handler's return.

---
 rtl/interrupt_controller_pkg.sv | 31 +++
 rtl/irq_priority_encoder.sv | 20 ++
 rtl/interrupt_controller.sv | 134 +++++++++++++
 tb/tb_interrupt_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared encodings for the interrupt controller
// and the hazard control unit handshake.
package interrupt_controller_pkg;

    localparam logic [3:0] CTRL_ST_INTERRUPT = 4'h2;

    typedef enum logic [1:0] {
        CFG_ENABLE   = 2'd0,
        CFG_GIE      = 2'd1,
        CFG_PEND_CLR = 2'd2,
        CFG_SW_SET   = 2'd3
    } cfg_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Vector address; wraps modulo 2^14.
    function automatic logic [13:0] vec_addr(
        input logic [13:0] base,
        input logic [13:0] stride,
        input logic [3:0]  id
    );
        logic [13:0] off;
        off = 14'(id) * stride;
        return base + off;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: lowest set bit wins; reusable by other arbiters.
// Purely combinational.
module irq_priority_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [3:0]       idx
);

    // Scan high to low so the lowest set index is the final assignment.
    always_comb begin
        valid = |req;
        idx   = 4'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches edge-triggered interrupt requests and
// presents the winning source to the hazard control unit.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [13:0] VEC_BASE   = 14'h0100,
    parameter logic [13:0] VEC_STRIDE = 14'h0004
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [3:0]         control_state,
    input  logic               iret,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               interrupt,
    output logic [13:0]        interrupt_vector_address,
    output logic [3:0]         active_id,
    output logic               in_service
);

    irq_state_e         state;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] irq_prev;
    logic               gie;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] wmask;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] ack_mask;
    logic               ack;
    logic               win_valid;
    logic [3:0]         win_idx;
    logic               cfg_unused;

    assign wmask      = cfg_wdata[NUM_SRC-1:0];
    assign cfg_unused = ^cfg_wdata;
    assign eligible   = pending & enable & {NUM_SRC{gie}};
    assign ack        = (state == ST_REQUEST) &&
                        (control_state == CTRL_ST_INTERRUPT);

    irq_priority_encoder #(
        .WIDTH (NUM_SRC)
    ) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Build the per-bit set and clear masks for pending.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_mask[i] = ack && (active_id == 4'(i));
        end
        set_mask = irq_in & ~irq_prev;
        clr_mask = ack_mask;
        if (cfg_we && cfg_addr == CFG_SW_SET)   set_mask = set_mask | wmask;
        if (cfg_we && cfg_addr == CFG_PEND_CLR) clr_mask = clr_mask | wmask;
    end

    // Pending, enable and gie registers; set wins over clear.
    always_ff @(negedge clock) begin
        if (!nreset) begin
            irq_prev <= '0;
            pending  <= '0;
            enable   <= '0;
            gie      <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr_mask) | set_mask;
            if (cfg_we && cfg_addr == CFG_ENABLE) enable <= wmask;
            if (cfg_we && cfg_addr == CFG_GIE)    gie    <= cfg_wdata[0];
        end
    end

    // Request FSM; once raised a request is held until acknowledge.
    always_ff @(negedge clock) begin
        if (!nreset) begin
            state                    <= ST_IDLE;
            interrupt                <= 1'b0;
            interrupt_vector_address <= VEC_BASE;
            active_id                <= 4'd0;
            in_service               <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        active_id <= win_idx;
                        interrupt_vector_address <=
                            vec_addr(VEC_BASE, VEC_STRIDE, win_idx);
                        interrupt <= 1'b1;
                        state     <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (ack) begin
                        interrupt  <= 1'b0;
                        in_service <= 1'b1;
                        state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (iret) begin
                        in_service <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    interrupt  <= 1'b0;
                    in_service <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Readback of the addressed register, zero extended.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_ENABLE:   cfg_rdata[NUM_SRC-1:0] = enable;
            CFG_GIE:      cfg_rdata[0] = gie;
            CFG_PEND_CLR: cfg_rdata[NUM_SRC-1:0] = pending;
            CFG_SW_SET:   cfg_rdata[NUM_SRC-1:0] = pending;
            default:      cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed stimulus with a request scoreboard;
// a default instance plus a wrapping-vector instance.
module tb_interrupt_controller;

    typedef struct packed {
        logic [13:0] vec;
        logic [3:0]  id;
    } exp_t;

    logic        clock = 1'b0;
    logic        nreset;
    logic [7:0]  irq_in;
    logic [3:0]  control_state;
    logic        iret;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        interrupt;
    logic [13:0] interrupt_vector_address;
    logic [3:0]  active_id;
    logic        in_service;

    logic [7:0]  w_irq_in;
    logic        w_cfg_we;
    logic [1:0]  w_cfg_addr;
    logic [15:0] w_cfg_wdata;
    logic [15:0] w_cfg_rdata;
    logic        w_interrupt;
    logic [13:0] w_vec;
    logic [3:0]  w_active_id;
    logic        w_in_service;

    int tests = 0;
    int fails = 0;
    exp_t sb_q[$];
    exp_t w_q[$];

    interrupt_controller u_dut (
        .clock                    (clock),
        .nreset                   (nreset),
        .irq_in                   (irq_in),
        .control_state            (control_state),
        .iret                     (iret),
        .cfg_we                   (cfg_we),
        .cfg_addr                 (cfg_addr),
        .cfg_wdata                (cfg_wdata),
        .cfg_rdata                (cfg_rdata),
        .interrupt                (interrupt),
        .interrupt_vector_address (interrupt_vector_address),
        .active_id                (active_id),
        .in_service               (in_service)
    );

    interrupt_controller #(
        .NUM_SRC    (8),
        .VEC_BASE   (14'h3FFC),
        .VEC_STRIDE (14'h0004)
    ) u_wrap (
        .clock                    (clock),
        .nreset                   (nreset),
        .irq_in                   (w_irq_in),
        .control_state            (4'h0),
        .iret                     (1'b0),
        .cfg_we                   (w_cfg_we),
        .cfg_addr                 (w_cfg_addr),
        .cfg_wdata                (w_cfg_wdata),
        .cfg_rdata                (w_cfg_rdata),
        .interrupt                (w_interrupt),
        .interrupt_vector_address (w_vec),
        .active_id                (w_active_id),
        .in_service               (w_in_service)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One DUT cycle: through the negedge, ending at the posedge.
    task automatic tick();
        @(negedge clock);
        @(posedge clock);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic w_cfg_write(input logic [1:0] a, input logic [15:0] d);
        w_cfg_we    = 1'b1;
        w_cfg_addr  = a;
        w_cfg_wdata = d;
        tick();
        w_cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic ack();
        control_state = 4'h2;
        tick();
        control_state = 4'h0;
    endtask

    task automatic do_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    // Monitor for the default instance: compares on each new request.
    logic int_prev = 1'b0;
    always @(posedge clock) begin
        if (interrupt && !int_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_req", {14'h0, interrupt_vector_address, active_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("req_vector", 32'(interrupt_vector_address), 32'(e.vec));
                check("req_id", 32'(active_id), 32'(e.id));
            end
        end
        int_prev <= interrupt;
    end

    // Monitor for the wrapping instance.
    logic w_prev = 1'b0;
    always @(posedge clock) begin
        if (w_interrupt && !w_prev) begin
            if (w_q.size() == 0) begin
                check("wrap_unexpected_req", {14'h0, w_vec, w_active_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = w_q.pop_front();
                check("wrap_vector", 32'(w_vec), 32'(e.vec));
                check("wrap_id", 32'(w_active_id), 32'(e.id));
            end
        end
        w_prev <= w_interrupt;
    end

    initial begin
        logic [15:0] d;
        nreset = 1'b0;
        irq_in = '0;
        control_state = 4'h0;
        iret = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = 2'd0;
        cfg_wdata = '0;
        w_irq_in = '0;
        w_cfg_we = 1'b0;
        w_cfg_addr = 2'd0;
        w_cfg_wdata = '0;
        @(posedge clock);
        tick();
        tick();
        nreset = 1'b1;

        check("rst_interrupt", 32'(interrupt), 32'h0);
        check("rst_vector", 32'(interrupt_vector_address), 32'h0100);
        check("rst_active_id", 32'(active_id), 32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        rd(2'd0, d);
        check("rst_enable", 32'(d), 32'h0);

        // Basic request on source 3.
        cfg_write(2'd0, 16'h00FF);
        cfg_write(2'd1, 16'h0001);
        sb_q.push_back('{vec: 14'h010C, id: 4'd3});
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        check("basic_latency_early", 32'(interrupt), 32'h0);
        tick();
        check("basic_interrupt", 32'(interrupt), 32'h1);
        ack();
        check("basic_ack_int", 32'(interrupt), 32'h0);
        check("basic_in_service", 32'(in_service), 32'h1);
        rd(2'd2, d);
        check("basic_pending_clr", 32'(d), 32'h0);
        do_iret();
        check("basic_iret", 32'(in_service), 32'h0);

        // Priority: 1 before 5.
        sb_q.push_back('{vec: 14'h0104, id: 4'd1});
        sb_q.push_back('{vec: 14'h0114, id: 4'd5});
        irq_in = 8'h22;
        tick();
        irq_in = 8'h00;
        tick();
        check("prio_first", 32'(interrupt), 32'h1);
        ack();
        do_iret();
        check("prio_idle_gap", 32'(interrupt), 32'h0);
        tick();
        check("prio_second", 32'(interrupt), 32'h1);
        ack();
        do_iret();

        // Gating by gie.
        cfg_write(2'd1, 16'h0000);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        check("gate_no_int", 32'(interrupt), 32'h0);
        rd(2'd2, d);
        check("gate_pending", 32'(d), 32'h0004);
        sb_q.push_back('{vec: 14'h0108, id: 4'd2});
        cfg_write(2'd1, 16'h0001);
        check("gate_not_yet", 32'(interrupt), 32'h0);
        tick();
        check("gate_int", 32'(interrupt), 32'h1);

        // Commitment: mask cleared while requesting.
        cfg_write(2'd0, 16'h0000);
        tick();
        check("commit_hold", 32'(interrupt), 32'h1);
        control_state = 4'h2;
        irq_in = 8'h04;
        tick();
        control_state = 4'h0;
        irq_in = 8'h00;
        check("commit_ack", 32'(interrupt), 32'h0);
        check("commit_service", 32'(in_service), 32'h1);
        rd(2'd2, d);
        check("set_over_clear", 32'(d), 32'h0004);
        do_iret();
        tick();
        check("masked_no_rereq", 32'(interrupt), 32'h0);
        cfg_write(2'd2, 16'h0004);
        rd(2'd2, d);
        check("w1c_pending", 32'(d), 32'h0);
        cfg_write(2'd0, 16'h00FF);

        // Reset mid-SERVICE.
        sb_q.push_back('{vec: 14'h0100, id: 4'd0});
        cfg_write(2'd3, 16'h0001);
        tick();
        check("sw_int", 32'(interrupt), 32'h1);
        ack();
        cfg_write(2'd3, 16'h0030);
        rd(2'd2, d);
        check("svc_pending", 32'(d), 32'h0030);
        check("svc_no_nest", 32'(interrupt), 32'h0);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("rst2_in_service", 32'(in_service), 32'h0);
        check("rst2_interrupt", 32'(interrupt), 32'h0);
        check("rst2_vector", 32'(interrupt_vector_address), 32'h0100);
        rd(2'd2, d);
        check("rst2_pending", 32'(d), 32'h0);
        rd(2'd0, d);
        check("rst2_enable", 32'(d), 32'h0);
        tick();
        tick();
        check("rst2_idle", 32'(interrupt), 32'h0);

        // Vector wrap via software trigger on the second instance.
        w_cfg_write(2'd0, 16'h00FF);
        w_cfg_write(2'd1, 16'h0001);
        w_q.push_back('{vec: 14'h0000, id: 4'd1});
        w_cfg_write(2'd3, 16'h0002);
        tick();
        check("wrap_int", 32'(w_interrupt), 32'h1);
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        check("wrap_sb_drained", 32'(w_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
